// File: rtl/riscv_pkg.sv
// Shared definitions for the prefetching instruction-fetch stage.
package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } if_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/riscv_if_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {pc, inst} pairs.
module riscv_if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/riscv_if_prefetch.sv
// Instruction-fetch stage with a prefetch queue between the I-cache and the IF/ID register.
module riscv_if_prefetch
    import riscv_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          BYTE_SWAP = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    input  logic                        stall,
    output logic                        ICACHE_ren,
    output logic                        ICACHE_wen,
    output logic [29:0]                 ICACHE_addr,
    input  logic [31:0]                 ICACHE_rdata,
    output logic [31:0]                 ICACHE_wdata,
    input  logic                        ICACHE_stall,
    output logic [31:0]                 inst_ppl,
    output logic [31:0]                 pc_ppl,
    output logic                        inst_valid_ppl,
    output logic [31:0]                 PC,
    output logic [$clog2(DEPTH+1)-1:0]  q_count
);

    localparam int            CW   = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if_state_t   state, state_next;
    logic [31:0] fpc, fpc_next;
    logic [31:0] pend_pc, pend_next;
    logic        outstanding_r;
    logic        accept, outstanding;
    logic [31:0] rdata_sw, redirect_tgt;
    logic        push, pop, q_empty;
    logic [63:0] q_head;
    logic [31:0] inst_next, pc_next;
    logic        valid_next;

    // A request is held (same address) until the cache drops its stall.
    assign ICACHE_ren   = outstanding_r | (q_count < FULL);
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = '0;
    assign ICACHE_addr  = fpc[31:2];
    assign PC           = fpc;

    assign accept       = ICACHE_ren & ~ICACHE_stall;
    assign outstanding  = ICACHE_ren & ICACHE_stall;
    assign rdata_sw     = BYTE_SWAP ? bswap32(ICACHE_rdata) : ICACHE_rdata;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign q_empty      = (q_count == '0);

    riscv_if_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (redirect_valid),
        .din   ({fpc, rdata_sw}),
        .dout  (q_head),
        .count (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            fpc            <= RESET_PC;
            pend_pc        <= '0;
            outstanding_r  <= 1'b0;
            inst_ppl       <= NOP_INST;
            pc_ppl         <= '0;
            inst_valid_ppl <= 1'b0;
        end else begin
            state          <= state_next;
            fpc            <= fpc_next;
            pend_pc        <= pend_next;
            outstanding_r  <= outstanding;
            inst_ppl       <= inst_next;
            pc_ppl         <= pc_next;
            inst_valid_ppl <= valid_next;
        end
    end

    // In DROP the response to the pre-redirect address is swallowed before
    // the pending target is adopted, so the cache never sees an address change mid-miss.
    always_comb begin
        state_next = state;
        fpc_next   = fpc;
        pend_next  = pend_pc;
        push       = 1'b0;
        pop        = 1'b0;
        inst_next  = inst_ppl;
        pc_next    = pc_ppl;
        valid_next = inst_valid_ppl;

        case (state)
            RUN: begin
                if (redirect_valid) begin
                    if (outstanding) begin
                        pend_next  = redirect_tgt;
                        state_next = DROP;
                    end else begin
                        fpc_next = redirect_tgt;
                    end
                end else if (accept) begin
                    fpc_next = fpc + 32'd4;
                end
            end
            DROP: begin
                if (accept) begin
                    fpc_next   = redirect_valid ? redirect_tgt : pend_pc;
                    state_next = RUN;
                end else if (redirect_valid) begin
                    pend_next = redirect_tgt;
                end
            end
            default: state_next = RUN;
        endcase

        if (redirect_valid) begin
            inst_next  = NOP_INST;
            pc_next    = redirect_tgt;
            valid_next = 1'b0;
        end else if (!stall) begin
            if (!q_empty) begin
                pop        = 1'b1;
                push       = accept && (state == RUN);
                pc_next    = q_head[63:32];
                inst_next  = q_head[31:0];
                valid_next = 1'b1;
            end else if (accept && (state == RUN)) begin
                pc_next    = fpc;
                inst_next  = rdata_sw;
                valid_next = 1'b1;
            end else begin
                pc_next    = fpc;
                inst_next  = NOP_INST;
                valid_next = 1'b0;
            end
        end else begin
            push = accept && (state == RUN);
        end
    end

endmodule

// File: doc/riscv_if_prefetch.md
Name: riscv_if_prefetch

Overview:
- Parametrised successor to the single-register IF stage; decouples I-cache fetch from ID by a DEPTH-entry prefetch queue.
- Fetches sequentially from an internal fetch PC and byte-swaps little-endian cache data.
- Feeds the IF/ID pipeline register and redirects on a single merged jump/branch port.
- Redirects that arrive mid-miss are handled safely: the cache address never changes while the cache is stalled.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- BYTE_SWAP, 1, 1 = reverse byte order of ICACHE_rdata before use; 0 = pass through.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  taken jal/jalr/branch; ID/EX merges the sources and resolves priority.
- redirect_pc  in  32  target; bits [1:0] ignored (treated as 0).
- stall  in  1  ID not accepting; hold IF/ID register.
- ICACHE_ren  out  1  read request.
- ICACHE_wen  out  1  constant 0.
- ICACHE_addr  out  30  word address = fpc[31:2].
- ICACHE_rdata  in  32  read data, valid in a cycle with ren=1 and ICACHE_stall=0.
- ICACHE_wdata  out  32  constant 0.
- ICACHE_stall  in  1  cache miss in progress.
- inst_ppl  out  32  IF/ID instruction.
- pc_ppl  out  32  IF/ID PC.
- inst_valid_ppl  out  1  IF/ID entry is a real fetched instruction (0 = bubble NOP).
- PC  out  32  current fetch PC (fpc).
- q_count  out  $clog2(DEPTH+1)  queue occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - fpc=RESET_PC, queue empty, q_count=0.
  - inst_ppl=NOP (32'h00000013), pc_ppl=0, inst_valid_ppl=0.
  - state=RUN, outstanding_r=0.
- Request rule: ICACHE_ren = outstanding_r | (q_count<DEPTH).
  - Accept = ren & ~ICACHE_stall. Outstanding = ren & ICACHE_stall; outstanding_r <= Outstanding.
  - While outstanding_r=1, ren stays 1 and ICACHE_addr stays unchanged. Space reserved at issue is guaranteed because only pops occur meanwhile.
- Accept in RUN with no redirect:
  - Entry {fpc, swap(rdata)} is produced; fpc <= fpc+4 (32-bit wrap at FFFF_FFFC -> 0).
- IF/ID update when stall=0:
  - If queue non-empty: pop head to ppl, valid=1; the accepted entry is pushed to the tail.
  - Else if accept this cycle: bypass entry directly to ppl, valid=1. One-cycle hit latency: address in cycle N, inst_ppl in N+1.
  - Else: inst_ppl=NOP, pc_ppl=fpc, valid=0.
- IF/ID update when stall=1: ppl holds; an accepted entry is pushed to the queue.
- Push and pop in the same cycle: q_count unchanged. Pointers wrap modulo DEPTH.
- Redirect handling (redirect has priority over stall):
  - The queue is cleared and ppl <= NOP, valid=0.
  - No outstanding request (including the cycle the stall falls): any same-cycle accept is discarded; fpc <= redirect_pc; state stays RUN.
  - Outstanding request: pend_pc <= redirect_pc; state -> DROP.
- DROP state:
  - ren=1 at the old address until accept; the accepted response is discarded, fpc <= pend_pc, state -> RUN.
  - A further redirect while in DROP overwrites pend_pc and again clears the queue and ppl.
  - No pushes occur in DROP.
- FSM: RUN <-> DROP only.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INST = 32'h00000013;
  - if_state_t {RUN, DROP};
  - function bswap32.
- One sub-module, riscv_if_fifo: DEPTH×64-bit synchronous FIFO with push, pop, clear, count, async active-low reset. Clear has priority over push.

Test Plan:
- Reset release, cache always hit -> ICACHE_addr 0,1,2,…; inst_ppl = swapped rdata from cycle 1; pc_ppl 0,4,8; q_count stays 0 (bypass).
- stall=1 for 6 cycles, DEPTH=4 -> queue fills to 4, ren drops to 0, PC holds at 0x10+base. stall release -> 4 queued instructions emerge in order, no gaps.
- ICACHE_stall=1 for 5 cycles at addr 0x20 -> addr stable, inst_valid_ppl=0 with NOP. On release -> inst 0x20 appears next cycle.
- redirect_pc=0x100 while no miss and 2 entries queued -> next cycle q_count=0, valid=0. Following cycle ICACHE_addr=0x40; first valid pc_ppl=0x100.
- redirect to 0x200 during miss at 0x30, then redirect to 0x300 before miss ends -> addr stays 0x0C until stall falls, that data never reaches ppl; next addr 0xC0, first valid pc_ppl=0x300.
- rst_n asserted asynchronously mid-miss with 3 entries queued -> outputs return to reset values immediately, without waiting for a clock edge; fetch restarts at RESET_PC.
